// File: rtl/status_flag_unit.sv
// Purpose : condition-flag register {z,c,n,v} with a 2-stage ALU flag-update
//           pipeline, direct flag write, and an exception save/restore slot.
// Latency : 2 clk edges from alu_valid/s_bit sample to sr; msr_we, exc_* 1 edge.
// Backpressure: none; consumer stalls conditional instructions on sr_pending.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   alu_valid/s_bit ALU result present / flag update requested
//   logic_op        1: C from shifter_carry and V kept; 0: C/V from the adder
//   alu_result, alu_carry, alu_overflow, shifter_carry  ALU/shifter outputs
//   msr_we/msr_data direct flag write, packed {z,c,n,v}
//   exc_entry       save next sr into spsr
//   exc_return      restore sr from spsr and flush stage 1
//   sr, spsr        current / saved flags, packed {z,c,n,v}
//   sr_pending      an update sits in stage 1, sr is not final
//   sr_updated      one-cycle pulse after an edge that changed sr
module status_flag_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic        s_bit,
  input  logic        logic_op,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  input  logic        shifter_carry,
  input  logic        msr_we,
  input  logic [3:0]  msr_data,
  input  logic        exc_entry,
  input  logic        exc_return,
  output logic [3:0]  sr,
  output logic [3:0]  spsr,
  output logic        sr_pending,
  output logic        sr_updated
);

  // stage-1 capture of the ALU outputs
  logic        s1_valid;
  logic [31:0] s1_result;
  logic        s1_alu_carry;
  logic        s1_overflow;
  logic        s1_shifter_carry;
  logic        s1_logic_op;

  logic [3:0]  commit_flags;
  logic        commit_fires;
  logic [3:0]  sr_next;
  logic [3:0]  spsr_next;
  logic        s1_valid_next;

  always_comb begin
    commit_flags    = sr;
    commit_flags[3] = (s1_result == 32'd0);
    commit_flags[2] = s1_logic_op ? s1_shifter_carry : s1_alu_carry;
    commit_flags[1] = s1_result[31];
    // logical ops keep V from the flags as they stand in the commit cycle
    commit_flags[0] = s1_logic_op ? sr[0] : s1_overflow;

    // a stage-2 commit only lands when neither higher-priority writer is active
    commit_fires = s1_valid && !msr_we && !exc_return;

    sr_next = sr;
    if (exc_return) begin
      sr_next = spsr;
    end else if (msr_we) begin
      sr_next = msr_data;
    end else if (s1_valid) begin
      sr_next = commit_flags;
    end

    // when entry and return coincide, the return wins and spsr is held
    spsr_next = spsr;
    if (exc_entry && !exc_return) begin
      spsr_next = commit_fires ? commit_flags : sr;
    end

    s1_valid_next = alu_valid && s_bit && !exc_return;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid         <= 1'b0;
      s1_result        <= 32'd0;
      s1_alu_carry     <= 1'b0;
      s1_overflow      <= 1'b0;
      s1_shifter_carry <= 1'b0;
      s1_logic_op      <= 1'b0;
      sr               <= 4'b0000;
      spsr             <= 4'b0000;
      sr_updated       <= 1'b0;
    end else begin
      s1_valid <= s1_valid_next;
      // operands only load on a real flag-update request; s_bit=0 leaves them alone
      if (alu_valid && s_bit) begin
        s1_result        <= alu_result;
        s1_alu_carry     <= alu_carry;
        s1_overflow      <= alu_overflow;
        s1_shifter_carry <= shifter_carry;
        s1_logic_op      <= logic_op;
      end
      sr         <= sr_next;
      spsr       <= spsr_next;
      // same-value writes produce no pulse
      sr_updated <= (sr_next != sr);
    end
  end

  assign sr_pending = s1_valid;

endmodule

// File: tb/tb_status_flag_unit.sv
module tb_status_flag_unit;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        s_bit;
  logic        logic_op;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_overflow;
  logic        shifter_carry;
  logic        msr_we;
  logic [3:0]  msr_data;
  logic        exc_entry;
  logic        exc_return;
  logic [3:0]  sr;
  logic [3:0]  spsr;
  logic        sr_pending;
  logic        sr_updated;

  int n_cmp;
  int n_bad;
  logic [3:0] exp_q[$];

  status_flag_unit dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .s_bit        (s_bit),
    .logic_op     (logic_op),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .shifter_carry(shifter_carry),
    .msr_we       (msr_we),
    .msr_data     (msr_data),
    .exc_entry    (exc_entry),
    .exc_return   (exc_return),
    .sr           (sr),
    .spsr         (spsr),
    .sr_pending   (sr_pending),
    .sr_updated   (sr_updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // pop the next scoreboard entry and compare it against sr
  task automatic chk_sr_sb(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, sr);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {28'd0, sr}, {28'd0, e});
    end
  endtask

  task automatic idle();
    alu_valid = 0; s_bit = 0; logic_op = 0; alu_result = 0;
    alu_carry = 0; alu_overflow = 0; shifter_carry = 0;
    msr_we = 0; msr_data = 0; exc_entry = 0; exc_return = 0;
  endtask

  task automatic drive_upd(input logic lop, input logic [31:0] res,
                           input logic cy, input logic ov, input logic sc,
                           input logic [3:0] expect_sr);
    alu_valid = 1; s_bit = 1; logic_op = lop; alu_result = res;
    alu_carry = cy; alu_overflow = ov; shifter_carry = sc;
    exp_q.push_back(expect_sr);
  endtask

  task automatic write_msr(input logic [3:0] d);
    msr_we = 1; msr_data = d;
    exp_q.push_back(d);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst = 1;
    tick(); tick();
    chk("rst_sr", {28'd0, sr}, 32'h0);
    chk("rst_spsr", {28'd0, spsr}, 32'h0);
    chk("rst_pending", {31'd0, sr_pending}, 32'h0);
    chk("rst_updated", {31'd0, sr_updated}, 32'h0);
    rst = 0;
    tick();

    // arithmetic update: result 0, carry 1 -> z=1 c=1
    drive_upd(0, 32'h0, 1, 0, 0, 4'b1100);
    tick(); idle();
    chk("arith_pend1", {31'd0, sr_pending}, 32'h1);
    chk("arith_sr_hold", {28'd0, sr}, 32'h0);
    tick();
    chk_sr_sb("arith_sr");
    chk("arith_pend0", {31'd0, sr_pending}, 32'h0);
    chk("arith_upd1", {31'd0, sr_updated}, 32'h1);
    tick();
    chk("arith_upd0", {31'd0, sr_updated}, 32'h0);

    // logical update keeps V
    write_msr(4'b0001);
    tick(); idle();
    chk_sr_sb("msr_0001");
    drive_upd(1, 32'h8000_0000, 1, 0, 0, 4'b0011);
    tick(); idle(); tick();
    chk_sr_sb("logic_keep_v");

    // same-value write gives no pulse
    tick();
    write_msr(4'b0011);
    tick(); idle();
    chk_sr_sb("msr_same");
    chk("same_no_pulse", {31'd0, sr_updated}, 32'h0);

    // msr collides with commit: msr wins
    drive_upd(0, 32'h0, 0, 0, 0, 4'b1000);
    void'(exp_q.pop_back());
    tick(); idle();
    write_msr(4'b0110);
    tick(); idle();
    chk_sr_sb("msr_collide");
    chk("collide_pend", {31'd0, sr_pending}, 32'h0);

    // update sampled in the same cycle as msr still commits afterwards
    write_msr(4'b0000);
    drive_upd(0, 32'h1, 1, 1, 0, 4'b0101);
    tick(); idle();
    chk_sr_sb("msr_then_upd_a");
    chk("msr_then_upd_pend", {31'd0, sr_pending}, 32'h1);
    tick();
    chk_sr_sb("msr_then_upd_b");

    // exception round trip with flush
    write_msr(4'b1010);
    tick(); idle();
    chk_sr_sb("pre_exc");
    exc_entry = 1;
    tick(); idle();
    chk("exc_spsr", {28'd0, spsr}, 32'ha);
    write_msr(4'b0000);
    tick(); idle();
    chk_sr_sb("exc_clear");
    drive_upd(0, 32'h0, 1, 0, 0, 4'b1010);
    tick(); idle();
    exc_return = 1;
    tick(); idle();
    chk_sr_sb("exc_ret_sr");
    chk("exc_ret_pend", {31'd0, sr_pending}, 32'h0);
    tick();
    chk("exc_flushed", {28'd0, sr}, 32'ha);

    // exc_entry during a commit saves the commit value
    drive_upd(0, 32'hFFFF_FFFF, 0, 0, 0, 4'b0010);
    tick(); idle();
    exc_entry = 1;
    tick(); idle();
    chk_sr_sb("entry_commit_sr");
    chk("entry_commit_spsr", {28'd0, spsr}, 32'h2);

    // entry + return together: return wins, spsr holds
    write_msr(4'b0101);
    tick(); idle();
    chk_sr_sb("pre_both");
    exc_entry = 1; exc_return = 1;
    exp_q.push_back(4'b0010);
    tick(); idle();
    chk_sr_sb("both_sr");
    chk("both_spsr", {28'd0, spsr}, 32'h2);

    // back-to-back updates
    drive_upd(0, 32'h0, 0, 0, 0, 4'b1000);
    tick();
    chk("b2b_pend0", {31'd0, sr_pending}, 32'h1);
    drive_upd(0, 32'h1, 0, 0, 0, 4'b0000);
    tick();
    chk_sr_sb("b2b_0");
    chk("b2b_pend1", {31'd0, sr_pending}, 32'h1);
    drive_upd(0, 32'hFFFF_FFFF, 0, 0, 0, 4'b0010);
    tick(); idle();
    chk_sr_sb("b2b_1");
    chk("b2b_pend2", {31'd0, sr_pending}, 32'h1);
    tick();
    chk_sr_sb("b2b_2");
    chk("b2b_pend3", {31'd0, sr_pending}, 32'h0);

    // alu_valid without s_bit changes nothing
    alu_valid = 1; s_bit = 0; alu_result = 32'h0; alu_carry = 1;
    tick(); idle();
    chk("nos_pend", {31'd0, sr_pending}, 32'h0);
    tick();
    chk("nos_sr", {28'd0, sr}, 32'h2);

    // async reset mid-flight
    drive_upd(0, 32'h0, 1, 0, 0, 4'b1100);
    void'(exp_q.pop_back());
    tick(); idle();
    chk("mid_pend", {31'd0, sr_pending}, 32'h1);
    #2 rst = 1;
    #1;
    chk("arst_sr", {28'd0, sr}, 32'h0);
    chk("arst_spsr", {28'd0, spsr}, 32'h0);
    chk("arst_pend", {31'd0, sr_pending}, 32'h0);
    tick();
    rst = 0;
    tick();
    chk("post_rst_sr", {28'd0, sr}, 32'h0);
    chk("post_rst_upd", {31'd0, sr_updated}, 32'h0);

    // first edge after release accepts a sample
    drive_upd(0, 32'h1, 0, 1, 0, 4'b0001);
    tick(); idle();
    chk("rel_pend", {31'd0, sr_pending}, 32'h1);
    tick();
    chk_sr_sb("rel_sr");

    chk("sb_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
